// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: five extension modes into a 2-entry in-order output FIFO.
// Optional saturating illegal-mode counter on err_cnt, enabled by defining EXT_ERR_CNT_EN.
module imm_ext_pipe #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int TAG_W     = 5,
  parameter int ERR_CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_extop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
`ifdef EXT_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  // Returns {illegal, extended}; illegal modes produce a zero result.
  function automatic logic [OUT_W:0] ext_imm(input logic [IN_W-1:0] imm,
                                             input logic [2:0]      op);
    logic signed [IN_W-1:0]  s_imm;
    logic signed [OUT_W-1:0] s_ext;
    logic [OUT_W-1:0]        z_ext;
    logic [OUT_W-1:0]        res;
    logic                    ill;
    s_imm = imm;
    s_ext = OUT_W'(s_imm);
    z_ext = {{(OUT_W-IN_W){1'b0}}, imm};
    ill   = 1'b0;
    case (op)
      3'b000:  res = z_ext;
      3'b001:  res = s_ext;
      3'b010:  res = z_ext << (OUT_W - IN_W);
      3'b011:  res = s_ext <<< 2;
      3'b100:  res = z_ext << 2;
      default: begin
        res = '0;
        ill = 1'b1;
      end
    endcase
    return {ill, res};
  endfunction

  logic [1:0]       r_count;
  logic [OUT_W-1:0] r_imm_hd, r_imm_tl;
  logic [TAG_W-1:0] r_tag_hd, r_tag_tl;
  logic             r_ill_hd, r_ill_tl;

  logic             w_push;
  logic             w_pop;
  logic [OUT_W:0]   w_ext;
  logic [OUT_W-1:0] w_new_imm;
  logic             w_new_ill;

  assign in_ready  = !rst && (r_count != CNT_FULL);
  assign out_valid = (r_count != CNT_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_ext     = ext_imm(in_imm, in_extop);
  assign w_new_imm = w_ext[OUT_W-1:0];
  assign w_new_ill = w_ext[OUT_W];

  // Head entry always drives the outputs; it is left untouched on the final pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= CNT_EMPTY;
      r_imm_hd <= '0;
      r_imm_tl <= '0;
      r_tag_hd <= '0;
      r_tag_tl <= '0;
      r_ill_hd <= 1'b0;
      r_ill_tl <= 1'b0;
    end else begin
      case (r_count)
        CNT_EMPTY: begin
          if (w_push) begin
            r_imm_hd <= w_new_imm;
            r_tag_hd <= in_tag;
            r_ill_hd <= w_new_ill;
            r_count  <= CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (w_push && w_pop) begin
            r_imm_hd <= w_new_imm;
            r_tag_hd <= in_tag;
            r_ill_hd <= w_new_ill;
          end else if (w_push) begin
            r_imm_tl <= w_new_imm;
            r_tag_tl <= in_tag;
            r_ill_tl <= w_new_ill;
            r_count  <= CNT_FULL;
          end else if (w_pop) begin
            r_count  <= CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (w_pop) begin
            r_imm_hd <= r_imm_tl;
            r_tag_hd <= r_tag_tl;
            r_ill_hd <= r_ill_tl;
            r_count  <= CNT_ONE;
          end
        end
        default: r_count <= CNT_EMPTY;
      endcase
    end
  end

  assign out_imm     = r_imm_hd;
  assign out_tag     = r_tag_hd;
  assign out_illegal = r_ill_hd;

`ifdef EXT_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_push && w_new_ill && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic [ERR_CNT_W-1:0] w_unused_err_cnt;
  assign w_unused_err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: 16/32 instance for mode, handshake and reset checks,
// plus an 8/16 instance for the narrow-width variant.
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [15:0] in_imm;
  logic [2:0]  in_extop;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_imm;
  logic [7:0]  err_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [7:0]  b_in_imm;
  logic [2:0]  b_in_extop, b_in_tag, b_out_tag;
  logic [15:0] b_out_imm;
  logic [3:0]  b_err_cnt;

  int n_asrt = 0;
  int n_fail = 0;

  logic [31:0] sweep_exp [5] = '{32'h00008001, 32'hFFFF8001, 32'h80010000,
                                 32'hFFFE0004, 32'h00020004};

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_extop(in_extop), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_illegal(out_illegal)
`ifdef EXT_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(3), .ERR_CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm),
    .in_extop(b_in_extop), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_tag(b_out_tag), .out_illegal(b_out_illegal)
`ifdef EXT_ERR_CNT_EN
    , .err_cnt(b_err_cnt)
`endif
  );

`ifndef EXT_ERR_CNT_EN
  assign err_cnt   = '0;
  assign b_err_cnt = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] op,
                       input logic [4:0] tag);
    in_valid = v;
    in_imm   = imm;
    in_extop = op;
    in_tag   = tag;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 16'h0, 3'b000, 5'd0);
    out_ready  = 1'b0;
    b_in_valid = 1'b0; b_in_imm = 8'h0; b_in_extop = 3'b000; b_in_tag = 3'd0;
    b_out_ready = 1'b0;
    #1 rst = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
`ifdef EXT_ERR_CNT_EN
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Mode sweep, back-to-back, one result per cycle
    out_ready = 1'b1;
    for (int m = 0; m < 5; m++) begin
      drive(1'b1, 16'h8001, 3'(m), 5'(m + 10));
      tick();
      chk($sformatf("sweep%0d_valid", m), 64'(out_valid), 64'd1);
      chk($sformatf("sweep%0d_imm", m), 64'(out_imm), 64'(sweep_exp[m]));
      chk($sformatf("sweep%0d_tag", m), 64'(out_tag), 64'(m + 10));
      chk($sformatf("sweep%0d_ill", m), 64'(out_illegal), 64'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_drain_valid", 64'(out_valid), 64'd0);

    // Illegal extop
    drive(1'b1, 16'h1234, 3'b101, 5'd7);
    tick();
    in_valid = 1'b0;
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_imm", 64'(out_imm), 64'd0);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_tag", 64'(out_tag), 64'd7);
`ifdef EXT_ERR_CNT_EN
    chk("ill_err_cnt", 64'(err_cnt), 64'd1);
`endif
    tick();
    chk("ill_drain_valid", 64'(out_valid), 64'd0);
    chk("empty_hold_tag", 64'(out_tag), 64'd7);
`ifdef EXT_ERR_CNT_EN
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 16'(k), 3'(5 + (k % 3)), 5'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("err_cnt_sat", 64'(err_cnt), 64'd255);
    tick();
    chk("err_cnt_sat_hold", 64'(err_cnt), 64'd255);
`endif

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 16'd1, 3'b000, 5'd1);
    tick();
    chk("bp_one_in_ready", 64'(in_ready), 64'd1);
    chk("bp_one_tag", 64'(out_tag), 64'd1);
    drive(1'b1, 16'd2, 3'b000, 5'd2);
    tick();
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_full_valid", 64'(out_valid), 64'd1);
    drive(1'b1, 16'd3, 3'b000, 5'd3);
    tick();
    chk("bp_held_in_ready", 64'(in_ready), 64'd0);
    chk("bp_held_tag", 64'(out_tag), 64'd1);
    chk("bp_held_imm", 64'(out_imm), 64'd1);
    tick();
    chk("bp_stable_tag", 64'(out_tag), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_tag", 64'(out_tag), 64'd2);
    chk("bp_pop1_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_pop2_tag", 64'(out_tag), 64'd3);
    chk("bp_pop2_imm", 64'(out_imm), 64'd3);
    chk("bp_pop2_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bp_drain_valid", 64'(out_valid), 64'd0);

    // Streaming with simultaneous push/pop
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 16'(i), 3'b001, 5'(i));
      tick();
      chk($sformatf("stream%0d_imm", i), 64'(out_imm), 64'(i));
      chk($sformatf("stream%0d_tag", i), 64'(out_tag), 64'(i));
      chk($sformatf("stream%0d_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset with buffer full
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 3'b000, 5'd9);
    tick();
    drive(1'b1, 16'hBBBB, 3'b000, 5'd10);
    tick();
    in_valid = 1'b0;
    chk("mid_full_in_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out_imm", 64'(out_imm), 64'd0);
`ifdef EXT_ERR_CNT_EN
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    #1 rst = 1'b0;
    #1;
    chk("mid_rel_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    drive(1'b1, 16'h0042, 3'b000, 5'd12);
    tick();
    in_valid = 1'b0;
    chk("after_rst_valid", 64'(out_valid), 64'd1);
    chk("after_rst_imm", 64'(out_imm), 64'h42);
    chk("after_rst_tag", 64'(out_tag), 64'd12);
    tick();
    chk("after_rst_single", 64'(out_valid), 64'd0);
    tick();
    chk("after_rst_no_stale", 64'(out_valid), 64'd0);

    // Narrow variant IN_W=8, OUT_W=16
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_imm = 8'h80; b_in_extop = 3'b011; b_in_tag = 3'd5;
    tick();
    chk("b_branch_imm", 64'(b_out_imm), 64'hFE00);
    chk("b_branch_valid", 64'(b_out_valid), 64'd1);
    chk("b_branch_tag", 64'(b_out_tag), 64'd5);
    b_in_extop = 3'b010; b_in_tag = 3'd6;
    tick();
    b_in_valid = 1'b0;
    chk("b_high_imm", 64'(b_out_imm), 64'h8000);
    chk("b_high_tag", 64'(b_out_tag), 64'd6);
    tick();
    chk("b_drain_valid", 64'(b_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
